// File: rtl/ge_pkg.sv
// Shared types and constants for the GE dealer: round FSM states, stage codes
// and the LFSR polynomial used as the random source.
`timescale 1ns/1ps
package ge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEAL1,
    S_WAIT1,
    S_DEAL2,
    S_WAIT2,
    S_DEAL3,
    S_WAIT3,
    S_DONE
  } state_t;

  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam logic [1:0]  STG_NONE    = 2'd0;
  localparam logic [1:0]  STG_COMMUTE = 2'd1;
  localparam logic [1:0]  STG_EXAM    = 2'd2;
  localparam logic [1:0]  STG_REPORT  = 2'd3;
  localparam logic [6:0]  STAGE3_MASK = 7'h07;

  // Right-shifting Galois step: the bit shifted out decides whether taps apply.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/ge_lfsr.sv
// Free-running 16-bit Galois LFSR; exposes its current state every cycle.
`timescale 1ns/1ps
module ge_lfsr
  import ge_pkg::*;
#(
  parameter logic [15:0] SEED = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] o_state
);

  // An all-zero seed would lock the register at zero forever.
  localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] r_state;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= INIT;
    else     r_state <= lfsr_next(r_state);
  end

  assign o_state = r_state;

endmodule

// File: rtl/ge_dealer.sv
// Round controller for the GE evaluator: deals one random word per stage over
// valid/ready, collects pass/fail results and keeps saturating round tallies.
`timescale 1ns/1ps
module ge_dealer
  import ge_pkg::*;
#(
  parameter logic [15:0] SEED    = 16'h0001,
  parameter int          ROUND_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               rnd_valid,
  input  logic               rnd_ready,
  output logic [6:0]         rnd_data,
  output logic [1:0]         rnd_stage,
  input  logic               res_valid,
  input  logic               res_pass,
  output logic               busy,
  output logic               round_done,
  output logic               round_win,
  output logic [ROUND_W-1:0] played,
  output logic [ROUND_W-1:0] won
);

  logic [15:0]        w_lfsr;
  logic               w_unused;
  state_t             r_state, w_state_nxt;
  logic               r_rnd_valid, w_valid_nxt;
  logic [6:0]         r_rnd_data, w_data_nxt;
  logic [1:0]         r_rnd_stage, w_stage_nxt;
  logic               w_finish, w_finish_win;
  logic               r_round_done, r_round_win;
  logic [ROUND_W-1:0] r_played, r_won, w_played_inc, w_won_inc;

  ge_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .o_state (w_lfsr)
  );

  // Only the low bits feed the deal words.
  assign w_unused = ^w_lfsr[15:7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rnd_valid <= 1'b0;
      r_rnd_data  <= '0;
      r_rnd_stage <= STG_NONE;
    end else begin
      r_state     <= w_state_nxt;
      r_rnd_valid <= w_valid_nxt;
      r_rnd_data  <= w_data_nxt;
      r_rnd_stage <= w_stage_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_valid_nxt  = r_rnd_valid;
    w_data_nxt   = r_rnd_data;
    w_stage_nxt  = r_rnd_stage;
    w_finish     = 1'b0;
    w_finish_win = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_DEAL1;
          w_valid_nxt = 1'b1;
          w_data_nxt  = w_lfsr[6:0];
          w_stage_nxt = STG_COMMUTE;
        end
      end
      S_DEAL1: begin
        if (r_rnd_valid && rnd_ready) begin
          w_state_nxt = S_WAIT1;
          w_valid_nxt = 1'b0;
        end
      end
      S_WAIT1: begin
        if (res_valid) begin
          if (res_pass) begin
            w_state_nxt = S_DEAL2;
            w_valid_nxt = 1'b1;
            w_data_nxt  = w_lfsr[6:0];
            w_stage_nxt = STG_EXAM;
          end else begin
            w_finish = 1'b1;
          end
        end
      end
      S_DEAL2: begin
        if (r_rnd_valid && rnd_ready) begin
          w_state_nxt = S_WAIT2;
          w_valid_nxt = 1'b0;
        end
      end
      S_WAIT2: begin
        if (res_valid) begin
          if (res_pass) begin
            w_state_nxt = S_DEAL3;
            w_valid_nxt = 1'b1;
            w_data_nxt  = w_lfsr[6:0] & STAGE3_MASK;
            w_stage_nxt = STG_REPORT;
          end else begin
            w_finish = 1'b1;
          end
        end
      end
      S_DEAL3: begin
        if (r_rnd_valid && rnd_ready) begin
          w_state_nxt = S_WAIT3;
          w_valid_nxt = 1'b0;
        end
      end
      S_WAIT3: begin
        if (res_valid) begin
          w_finish     = 1'b1;
          w_finish_win = res_pass;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // A failed stage or the final result ends the round immediately.
    if (w_finish) begin
      w_state_nxt = S_DONE;
      w_stage_nxt = STG_NONE;
    end
  end

  assign w_played_inc = (&r_played) ? r_played : r_played + ROUND_W'(1);
  assign w_won_inc    = (&r_won)    ? r_won    : r_won    + ROUND_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_round_done <= 1'b0;
      r_round_win  <= 1'b0;
      r_played     <= '0;
      r_won        <= '0;
    end else begin
      r_round_done <= w_finish;
      if (w_finish) begin
        r_round_win <= w_finish_win;
        r_played    <= w_played_inc;
        if (w_finish_win) r_won <= w_won_inc;
      end
    end
  end

  assign rnd_valid  = r_rnd_valid;
  assign rnd_data   = r_rnd_data;
  assign rnd_stage  = r_rnd_stage;
  assign busy       = (r_state != S_IDLE);
  assign round_done = r_round_done;
  assign round_win  = r_round_win;
  assign played     = r_played;
  assign won        = r_won;

endmodule
